dma_txn_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares the single DMA read/write channel pair between two requesters, such as the CPU memory controller and a host-side loader. It accepts single-cache-line read or write requests. For each one it issues a size-1 DMA transaction: go pulse, data transfer, then wait for done. It returns the read data or write completion to the requester that issued it. It sits between the requesters and the DMA interface in the AFU top level, which wires its `dma_*` ports to the corresponding DMA interface fields.

---
 rtl/dma_txn_arbiter_pkg.sv | 33 +++
 rtl/dma_txn_arbiter_if.sv | 53 +++++
 rtl/dma_txn_arbiter_rr_arb2.sv | 23 ++
 rtl/dma_txn_arbiter.sv | 121 ++++++++++++
 tb/tb_dma_txn_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dma_txn_arbiter_pkg.sv
// Shared types and constants for the DMA transaction arbiter.
//   state_t        : sequencer states
//   CL_BYTES       : cache-line size in bytes
//   CL_OFFSET_BITS : byte-offset bits inside a cache line
//   txn_t          : latched request (direction, line address, write data)
package dma_arb_pkg;

    localparam int CL_BYTES       = 64;
    localparam int CL_OFFSET_BITS = 6;

    // Struct fields are sized for the widest supported configuration; the
    // top level uses only the low ADDR_WIDTH / DATA_WIDTH bits.
    localparam int TXN_ADDR_W = 64;
    localparam int TXN_DATA_W = 512;

    typedef enum logic [2:0] {
        IDLE,
        RD_GO,
        RD_XFER,
        RD_WAIT,
        WR_GO,
        WR_XFER,
        WR_WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [TXN_ADDR_W-1:0] addr;
        logic [TXN_DATA_W-1:0] wdata;
    } txn_t;

endpackage

// File: rtl/dma_txn_arbiter_if.sv
// Bundle between the arbiter, its two requesters and the DMA channel pair.
//   req_*     : per-requester request handshake (index 0/1)
//   rsp_*     : completion pulse and read data back to the requesters
//   busy      : arbiter has a transaction in flight
//   dma_*     : read/write DMA channel control and data
// slave  : the arbiter itself
// master : the surrounding environment (requesters plus DMA engine)
interface dma_txn_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 43
);
    logic [1:0]            req_valid;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] dma_rd_addr;
    logic [ADDR_WIDTH-1:0] dma_wr_addr;
    logic [SIZE_WIDTH-1:0] dma_rd_size;
    logic [SIZE_WIDTH-1:0] dma_wr_size;
    logic                  dma_rd_go;
    logic                  dma_wr_go;
    logic                  dma_rd_en;
    logic                  dma_wr_en;
    logic [DATA_WIDTH-1:0] dma_wr_data;
    logic [DATA_WIDTH-1:0] dma_rd_data;
    logic                  dma_empty;
    logic                  dma_full;
    logic                  dma_rd_done;
    logic                  dma_wr_done;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy,
        output dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size,
        output dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, dma_wr_data,
        input  dma_rd_data, dma_empty, dma_full, dma_rd_done, dma_wr_done
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy,
        input  dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size,
        input  dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en, dma_wr_data,
        output dma_rd_data, dma_empty, dma_full, dma_rd_done, dma_wr_done
    );

endinterface

// File: rtl/dma_txn_arbiter_rr_arb2.sv
// Two-requester round-robin pick (purely combinational).
//   req         : request vector
//   last        : index granted most recently
//   grant       : one-hot winner (zero when nobody requests)
//   grant_valid : at least one requester is asking
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_valid
);

    always_comb begin
        grant = req;
        // On a tie the requester that did not win last time goes first.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

    assign grant_valid = |req;

endmodule

// File: rtl/dma_txn_arbiter.sv
// Shares one DMA read/write channel pair between two cache-line requesters.
// Each accepted request becomes a size-1 DMA transaction (go, one transfer,
// wait for done) and is answered with a one-cycle rsp_valid pulse.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : requester handshake, response and DMA channel signals
module dma_txn_arbiter
    import dma_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_WIDTH = 43
) (
    input logic              clk,
    input logic              rst,
    dma_txn_arbiter_if.slave bus
);

    state_t                state_q, state_d;
    logic                  last_q;
    logic [1:0]            gnt_q;
    txn_t                  txn_q, txn_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [1:0] arb_gnt;
    logic       arb_valid;
    logic       gnt_idx;
    logic       grant_fire;
    logic       rd_en_c;

    rr_arb2 u_rr_arb2 (
        .req         (bus.req_valid),
        .last        (last_q),
        .grant       (arb_gnt),
        .grant_valid (arb_valid)
    );

    assign gnt_idx = arb_gnt[1];
    // Blocking the grant while rst is high keeps req_ready at 0 during reset.
    assign grant_fire = (state_q == IDLE) && arb_valid && !rst;

    // Latch the winning request with the line offset cleared.
    always_comb begin
        txn_d       = '0;
        txn_d.we    = bus.req_we[gnt_idx];
        txn_d.addr  = TXN_ADDR_W'(bus.req_addr[gnt_idx]);
        txn_d.addr[CL_OFFSET_BITS-1:0] = '0;
        txn_d.wdata = TXN_DATA_W'(bus.req_wdata[gnt_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done is only looked at in the WAIT states, which are at least two
    // cycles past go, so a done left over from the previous job is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_fire) state_d = bus.req_we[gnt_idx] ? WR_GO : RD_GO;
            RD_GO:   state_d = RD_XFER;
            RD_XFER: if (!bus.dma_empty) state_d = RD_WAIT;
            RD_WAIT: if (bus.dma_rd_done) state_d = RESP;
            WR_GO:   state_d = WR_XFER;
            WR_XFER: if (!bus.dma_full) state_d = WR_WAIT;
            WR_WAIT: if (bus.dma_wr_done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.dma_rd_go = 1'b0;
        bus.dma_wr_go = 1'b0;
        rd_en_c       = 1'b0;
        bus.dma_wr_en = 1'b0;
        case (state_q)
            IDLE:    if (grant_fire) bus.req_ready = arb_gnt;
            RD_GO:   bus.dma_rd_go = 1'b1;
            RD_XFER: rd_en_c = !bus.dma_empty;
            WR_GO:   bus.dma_wr_go = 1'b1;
            WR_XFER: bus.dma_wr_en = !bus.dma_full;
            RESP:    bus.rsp_valid = gnt_q;
            default: ;
        endcase
    end

    assign bus.dma_rd_en   = rd_en_c;
    assign bus.busy        = (state_q != IDLE);
    assign bus.dma_rd_addr = txn_q.addr[ADDR_WIDTH-1:0];
    assign bus.dma_wr_addr = txn_q.addr[ADDR_WIDTH-1:0];
    assign bus.dma_rd_size = SIZE_WIDTH'(1);
    assign bus.dma_wr_size = SIZE_WIDTH'(1);
    assign bus.dma_wr_data = txn_q.wdata[DATA_WIDTH-1:0];
    assign bus.rsp_rdata   = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= 1'b1;
            gnt_q   <= '0;
            txn_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (grant_fire) begin
                last_q <= gnt_idx;
                gnt_q  <= arb_gnt;
                txn_q  <= txn_d;
            end
            // Read data is kept until the next read capture, across writes.
            if (rd_en_c && !txn_q.we) begin
                rdata_q <= bus.dma_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dma_txn_arbiter.sv
module tb_dma_txn_arbiter;
    import dma_arb_pkg::*;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = 43;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dma_txn_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

    dma_txn_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: pending requests, round-robin memory, last read.
    bit          pv     [2];
    bit          pwe    [2];
    logic [AW-1:0] paddr  [2];
    logic [DW-1:0] pwdata [2];
    bit          last_m;
    logic [DW-1:0] last_rdata;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_reqs();
        bus.req_valid    = {pv[1], pv[0]};
        bus.req_we       = {pwe[1], pwe[0]};
        bus.req_addr[0]  = paddr[0];
        bus.req_addr[1]  = paddr[1];
        bus.req_wdata[0] = pwdata[0];
        bus.req_wdata[1] = pwdata[1];
    endtask

    task automatic new_req(input int r);
        pv[r]     = 1'b1;
        pwe[r]    = 1'($urandom_range(0, 1));
        paddr[r]  = {$urandom, $urandom};
        pwdata[r] = rand_line();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, bus.req_ready, 0);
        chk({tag, "_rsp"}, bus.rsp_valid, 0);
        chk({tag, "_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rdaddr"}, bus.dma_rd_addr, 0);
        chk({tag, "_wraddr"}, bus.dma_wr_addr, 0);
        chk({tag, "_gos"}, {bus.dma_rd_go, bus.dma_wr_go}, 0);
        chk({tag, "_ens"}, {bus.dma_rd_en, bus.dma_wr_en}, 0);
        chk({tag, "_wrdata"}, bus.dma_wr_data, 0);
        chk({tag, "_rdsize"}, bus.dma_rd_size, 1);
        chk({tag, "_wrsize"}, bus.dma_wr_size, 1);
    endtask

    // One complete transaction starting at an IDLE negedge with requests driven.
    // xd: cycles of empty/full before the transfer, wd: cycles before done.
    task automatic txn(input int xd, input int wd, input logic [DW-1:0] rd, input bit refill);
        int            g;
        logic [1:0]    oh;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] wdat;
        if (pv[0] && pv[1]) g = last_m ? 0 : 1;
        else                g = pv[0] ? 0 : 1;
        oh   = (g == 0) ? 2'b01 : 2'b10;
        we   = pwe[g];
        a    = paddr[g] - (paddr[g] % CL_BYTES);
        wdat = pwdata[g];
        bus.dma_empty = (xd > 0);
        bus.dma_full  = (xd > 0);
        #1;
        chk("idle_busy", bus.busy, 0);
        chk("grant", bus.req_ready, oh);
        @(negedge clk);
        last_m = (g == 1);
        if (refill) new_req(g);
        else        pv[g] = 1'b0;
        drive_reqs();
        #1;
        chk("go_rd", bus.dma_rd_go, !we);
        chk("go_wr", bus.dma_wr_go, we);
        chk("ready_off", bus.req_ready, 0);
        chk("addr", we ? bus.dma_wr_addr : bus.dma_rd_addr, a);
        @(negedge clk);
        // DMA engine cleared done when it saw go.
        bus.dma_rd_done = 1'b0;
        bus.dma_wr_done = 1'b0;
        bus.dma_rd_data = rd;
        for (int i = 0; i < xd; i++) begin
            #1;
            chk("en_held", {bus.dma_rd_en, bus.dma_wr_en}, 0);
            @(negedge clk);
        end
        bus.dma_empty = 1'b0;
        bus.dma_full  = 1'b0;
        #1;
        chk("en_rd", bus.dma_rd_en, !we);
        chk("en_wr", bus.dma_wr_en, we);
        if (we) chk("wr_data", bus.dma_wr_data, wdat);
        @(negedge clk);
        bus.dma_rd_data = ~rd;
        for (int i = 0; i <= wd; i++) begin
            if (i == wd) begin
                if (we) bus.dma_wr_done = 1'b1;
                else    bus.dma_rd_done = 1'b1;
            end
            #1;
            chk("no_rsp_wait", bus.rsp_valid, 0);
            chk("en_once", {bus.dma_rd_en, bus.dma_wr_en}, 0);
            @(negedge clk);
        end
        #1;
        if (!we) last_rdata = rd;
        chk("rsp", bus.rsp_valid, oh);
        chk("rdata", bus.rsp_rdata, last_rdata);
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] line;
        for (int r = 0; r < 2; r++) begin
            pv[r] = 0; pwe[r] = 0; paddr[r] = '0; pwdata[r] = '0;
        end
        last_m = 1'b1;
        last_rdata = '0;
        drive_reqs();
        bus.dma_rd_data = '0;
        bus.dma_empty = 1'b0;
        bus.dma_full = 1'b0;
        bus.dma_rd_done = 1'b0;
        bus.dma_wr_done = 1'b0;

        // Power-on reset
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Read from requester 0, data after 3 empty cycles
        pv[0] = 1; pwe[0] = 0; paddr[0] = 64'h1000_0040;
        drive_reqs();
        txn(3, 1, {64{8'hA5}}, 0);

        // Write from requester 1, unaligned address, full for 5 cycles
        pv[1] = 1; pwe[1] = 1; paddr[1] = 64'h2000_0047;
        for (int b = 0; b < DW / 8; b++) pwdata[1][8*b +: 8] = 8'(b);
        drive_reqs();
        txn(5, 2, rand_line(), 0);

        // Both requesters held valid: grants alternate
        new_req(0);
        new_req(1);
        drive_reqs();
        for (int k = 0; k < 4; k++) txn($urandom_range(0, 2), $urandom_range(0, 2), rand_line(), 1);
        pv[0] = 0; pv[1] = 0;
        drive_reqs();
        @(negedge clk);

        // Stale read done from the previous job stays high through go
        bus.dma_rd_done = 1'b1;
        pv[0] = 1; pwe[0] = 0; paddr[0] = {$urandom, $urandom};
        drive_reqs();
        txn(0, 3, rand_line(), 0);

        // Randomized traffic
        for (int k = 0; k < 16; k++) begin
            for (int r = 0; r < 2; r++) if (!pv[r] && $urandom_range(0, 1) == 1) new_req(r);
            if (!pv[0] && !pv[1]) new_req($urandom_range(0, 1));
            drive_reqs();
            txn($urandom_range(0, 3), $urandom_range(0, 3), rand_line(), 0);
        end
        pv[0] = 0; pv[1] = 0;
        drive_reqs();
        @(negedge clk);

        // Reset in WR_WAIT abandons the write
        pv[0] = 1; pwe[0] = 1; paddr[0] = 64'h3000_0080; pwdata[0] = rand_line();
        drive_reqs();
        bus.dma_full = 1'b0;
        bus.dma_wr_done = 1'b0;
        #1;
        chk("rw_grant", bus.req_ready, 2'b01);
        @(negedge clk);
        pv[0] = 0;
        drive_reqs();
        @(negedge clk);
        #1;
        chk("rw_xfer", bus.dma_wr_en, 1);
        @(negedge clk);
        #1;
        chk("rw_wait_busy", bus.busy, 1);
        new_req(0);
        new_req(1);
        drive_reqs();
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        bus.dma_wr_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("rst_held");
        rst = 1'b0;
        last_m = 1'b1;
        last_rdata = '0;
        line = rand_line();
        txn(1, 0, line, 0);
        txn(0, 1, rand_line(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
